// File: rtl/isa_io_responder.sv
// isa_io_responder: ISA-side I/O cycle responder for the SM2201 ISA-CAMAC board.
// Decodes IOR/IOW into a 4-register window, sequences the 82x6 transceiver pair
// (xcvr_cs_n/xcvr_dce), stretches the ISA cycle through IOCHRDY wait states,
// latches host writes toward the CAMAC engine and returns CAMAC data/status.
// Ports: clk/rst; ISA side ior_n, iow_n, aen, addr, iochrdy; transceiver side
// xcvr_cs_n, xcvr_dce, d_from_bus, d_to_bus; CAMAC side camac_wdata, camac_naf,
// camac_start, camac_done, camac_rdata, camac_q, camac_x; proto_err pulse.
module isa_io_responder #(
  parameter int                    ADDR_WIDTH  = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 10'h300,
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    WAIT_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ior_n,
  input  logic                  iow_n,
  input  logic                  aen,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  iochrdy,
  output logic                  xcvr_cs_n,
  output logic                  xcvr_dce,
  input  logic [DATA_WIDTH-1:0] d_from_bus,
  output logic [DATA_WIDTH-1:0] d_to_bus,
  output logic [DATA_WIDTH-1:0] camac_wdata,
  output logic [DATA_WIDTH-1:0] camac_naf,
  output logic                  camac_start,
  input  logic                  camac_done,
  input  logic [DATA_WIDTH-1:0] camac_rdata,
  input  logic                  camac_q,
  input  logic                  camac_x,
  output logic                  proto_err
);

  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, HOLD} state_t;
  state_t state, state_nxt;

  // Synchronizers; *_s3 is the previous synced value for edge detection.
  logic ior_s1, ior_s2, ior_s3, iow_s1, iow_s2, iow_s3;
  logic armed;        // both synced strobes seen high since reset/protocol error
  logic cyc_wr;       // current cycle is a host write
  logic [1:0] idx;    // register index held for the whole cycle
  logic [CW-1:0] cnt;
  logic busy, q_lat, x_lat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ior_s1 <= 1'b1; ior_s2 <= 1'b1; ior_s3 <= 1'b1;
      iow_s1 <= 1'b1; iow_s2 <= 1'b1; iow_s3 <= 1'b1;
    end else begin
      ior_s1 <= ior_n; ior_s2 <= ior_s1; ior_s3 <= ior_s2;
      iow_s1 <= iow_n; iow_s2 <= iow_s1; iow_s3 <= iow_s2;
    end
  end

  logic ior_fall, iow_fall, hit, proto, acc_rd, acc_wr, last, wr_fire, start_ok;
  logic [1:0] wr_idx;
  logic [DATA_WIDTH-1:0] rd_val;

  always_comb begin
    ior_fall = armed & ior_s3 & ~ior_s2;
    iow_fall = armed & iow_s3 & ~iow_s2;
    hit      = ~aen && (addr[ADDR_WIDTH-1:2] == BASE_ADDR[ADDR_WIDTH-1:2]);
    // Both strobes low together is illegal; it outranks any edge seen with it.
    proto    = (state == IDLE) && armed && ~ior_s2 && ~iow_s2;
    acc_rd   = (state == IDLE) && ~proto && ior_fall && hit;
    acc_wr   = (state == IDLE) && ~proto && iow_fall && hit;
    last     = (cnt == LAST);
    // With no wait states the write lands on the accepting edge itself.
    wr_fire  = (WAIT_CYCLES == 0) ? acc_wr : ((state == WR_WAIT) && last);
    wr_idx   = (WAIT_CYCLES == 0) ? addr[1:0] : idx;
    // A completion arriving on the same edge frees the engine for the new start.
    start_ok = wr_fire && (wr_idx == 2'd3) && (~busy || camac_done);
    rd_val   = '0;
    case (addr[1:0])
      2'd0: rd_val = camac_rdata;
      2'd1: rd_val = camac_naf;
      2'd2: rd_val = {{(DATA_WIDTH-3){1'b0}}, x_lat, q_lat, busy};
      default: rd_val = camac_wdata;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (acc_rd)      state_nxt = (WAIT_CYCLES == 0) ? HOLD : RD_WAIT;
        else if (acc_wr) state_nxt = (WAIT_CYCLES == 0) ? HOLD : WR_WAIT;
      end
      RD_WAIT, WR_WAIT: if (last) state_nxt = HOLD;
      HOLD: if (cyc_wr ? iow_s2 : ior_s2) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Transceiver/ready outputs decode straight from state so reset clears them at once.
  assign iochrdy   = ~((state == RD_WAIT) || (state == WR_WAIT));
  assign xcvr_cs_n = (state == IDLE);
  assign xcvr_dce  = cyc_wr && (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed       <= 1'b0;
      cyc_wr      <= 1'b0;
      idx         <= 2'd0;
      cnt         <= '0;
      d_to_bus    <= '0;
      camac_wdata <= '0;
      camac_naf   <= '0;
      camac_start <= 1'b0;
      proto_err   <= 1'b0;
      busy        <= 1'b0;
      q_lat       <= 1'b0;
      x_lat       <= 1'b0;
    end else begin
      proto_err   <= proto;
      camac_start <= start_ok;
      if (proto)               armed <= 1'b0;
      else if (ior_s2 & iow_s2) armed <= 1'b1;

      if (acc_rd || acc_wr) begin
        cyc_wr <= acc_wr;
        idx    <= addr[1:0];
      end
      if (acc_rd) d_to_bus <= rd_val;

      if (state == IDLE) cnt <= '0;
      else if ((state == RD_WAIT || state == WR_WAIT) && !last) cnt <= cnt + CW'(1);

      if (wr_fire && wr_idx == 2'd0) camac_wdata <= d_from_bus;
      if (wr_fire && wr_idx == 2'd1) camac_naf   <= d_from_bus;

      if (start_ok)        busy <= 1'b1;
      else if (camac_done) busy <= 1'b0;

      if (camac_done) begin
        q_lat <= camac_q;
        x_lat <= camac_x;
      end else if (wr_fire && wr_idx == 2'd2) begin
        q_lat <= 1'b0;
        x_lat <= 1'b0;
      end
    end
  end

endmodule

// File: doc/isa_io_responder.md
Name: isa_io_responder

Overview:
- ISA-side I/O cycle responder for the SM2201 ISA–CAMAC interface board.
- Decodes ISA IOR/IOW cycles into a 4-register window.
- Sequences the cs_n/dce controls of the 82x6 data-bus transceiver pair and inserts IOCHRDY wait states.
- Latches written data toward the CAMAC cycle engine and returns CAMAC read data/status to the host.

Parameters:
- ADDR_WIDTH, 10, width of ISA I/O address compared.
- BASE_ADDR, 10'h300, window base; bits [1:0] must be 0.
- DATA_WIDTH, 8, data width (two 4-bit transceivers).
- WAIT_CYCLES, 4, clocks IOCHRDY is held low per accepted cycle; 0 = no wait states.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- ior_n  in  1  ISA I/O read strobe, asynchronous
- iow_n  in  1  ISA I/O write strobe, asynchronous
- aen  in  1  ISA DMA address enable; cycle ignored when 1
- addr  in  ADDR_WIDTH  ISA I/O address
- iochrdy  out  1  ISA ready; 0 inserts wait
- xcvr_cs_n  out  1  transceiver chip select, active low
- xcvr_dce  out  1  transceiver direction; 1 = bus->d_out (host write), 0 = d_in->bus (host read)
- d_from_bus  in  DATA_WIDTH  transceiver d_out (host write data)
- d_to_bus  out  DATA_WIDTH  transceiver d_in (host read data)
- camac_wdata  out  DATA_WIDTH  reg0, CAMAC write data
- camac_naf  out  DATA_WIDTH  reg1, CAMAC N/A/F code
- camac_start  out  1  one-clock start pulse
- camac_done  in  1  one-clock completion pulse
- camac_rdata  in  DATA_WIDTH  CAMAC read data
- camac_q  in  1  Q response, valid with camac_done
- camac_x  in  1  X response, valid with camac_done
- proto_err  out  1  one-clock pulse on illegal strobe combination

Behaviour:
- Reset, asynchronous: iochrdy=1, xcvr_cs_n=1, xcvr_dce=0, d_to_bus=0, camac_wdata=0, camac_naf=0, camac_start=0, proto_err=0, busy=0, q_lat=0, x_lat=0, FSM=IDLE, synchronizers=1.
- Reset mid-cycle: outputs return to the reset values immediately. After reset release, the FSM waits for both synced strobes to be high before accepting a new cycle.
- ior_n and iow_n each pass through a 2-flop synchronizer; a falling edge is detected on the synced value.
- Decode: hit when aen==0 and addr[ADDR_WIDTH-1:2]==BASE_ADDR[ADDR_WIDTH-1:2]. addr and aen are sampled in the edge-detect cycle; the sampled reg index is held for the whole cycle.
- Misses leave all outputs idle.
- FSM states: IDLE, RD_WAIT, WR_WAIT, HOLD.
- IDLE->RD_WAIT on decoded IOR edge:
  - xcvr_cs_n=0, xcvr_dce=0, iochrdy=0.
  - d_to_bus is loaded once at entry from the read mux and held stable.
  - Entry is on the 3rd rising clk edge after ior_n falls.
- IDLE->WR_WAIT on decoded IOW edge: xcvr_cs_n=0, xcvr_dce=1, iochrdy=0, same latency as RD_WAIT.
- Wait counter counts WAIT_CYCLES clocks in RD_WAIT/WR_WAIT, then the FSM enters HOLD with iochrdy=1.
- WAIT_CYCLES=0: iochrdy stays 1 and the FSM goes straight to HOLD.
- WR_WAIT exit: d_from_bus is latched into the indexed register on the final wait clock.
- HOLD: transceiver controls are held until the active strobe's synced value returns high. Then xcvr_cs_n=1, xcvr_dce=0 and the FSM returns to IDLE.
- Read mux:
  - idx0 = camac_rdata
  - idx1 = camac_naf
  - idx2 = {0…, x_lat, q_lat, busy} (busy in bit 0)
  - idx3 = camac_wdata
- Write map:
  - idx0 -> camac_wdata
  - idx1 -> camac_naf
  - idx2 -> clears q_lat and x_lat (data ignored)
  - idx3 -> start
- Start (write idx3): camac_start pulses one clock after the latch and busy is set. A start while busy=1 is ignored: no pulse, busy unchanged.
- camac_done: clears busy, latches q_lat=camac_q and x_lat=camac_x. If camac_done and a new start coincide, the start wins: busy=1 and the new pulse is issued, with q/x still latched.
- Both synced strobes low simultaneously in IDLE: no cycle starts, proto_err pulses once, FSM remains in IDLE until both strobes are high.
- An opposite strobe asserted during RD_WAIT/WR_WAIT/HOLD is ignored; the current cycle completes.
- Wait counter width is clog2(WAIT_CYCLES+1); no wrap-around occurs.

Test Plan:
- Write idx0 (addr 0x300, d_from_bus=8'h5A, WAIT_CYCLES=4):
  - xcvr_cs_n=0 and xcvr_dce=1 on the 3rd edge after iow_n falls.
  - iochrdy low for exactly 4 clocks.
  - camac_wdata=8'h5A.
  - xcvr_cs_n=1 3 edges after iow_n rises.
- Read idx0 with camac_rdata=8'hC3: xcvr_dce=0, d_to_bus=8'hC3 stable through HOLD, iochrdy low 4 clocks.
- Write idx3 -> camac_start single pulse, status read=8'h01. Then camac_done with q=1, x=0 -> status 8'h02. Write idx2 -> status 8'h00.
- Miss cases: addr=0x304 or aen=1 -> no change on xcvr_cs_n/iochrdy, registers unchanged.
- ior_n and iow_n both low -> proto_err one pulse, no transceiver activity.
- Reset asserted during WR_WAIT -> iochrdy=1 and xcvr_cs_n=1 immediately.
- Start while busy -> no second camac_start.
- done+start in the same cycle -> busy remains 1.
